a8_bus_responder: RTL and testbench

A8_BUS_RESPONDER -- requirements
Module: a8_bus_responder

---
 rtl/a8_bus_responder.sv | 217 +++++++++++++++++++++
 tb/tb_a8_bus_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a8_bus_responder.sv
// Atari 8-bit bus responder: a 16-byte register window served on the A8 bus, synchronised into clk200.
// Optional Math-Pak disable output is compiled in with A8_MPD_RESPONDER_EN.
module a8_bus_responder #(
  parameter logic [15:0] WINDOW_BASE = 16'hD1F0,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk200,
  input  logic        rst_n,
  input  logic        a8_clk,
  input  logic        a8_rw_n,
  input  logic        a8_rst_n,
  input  logic [15:0] a8_addr,
  input  logic [7:0]  a8_data_in,
  output logic [7:0]  a8_data_out,
  output logic        a8_data_oe,
  output logic        a8_extsel_n,
  output logic        a8_mpd_n,
  input  logic        reg_we,
  input  logic [3:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic        wr_evt,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        mpd_req,
  output logic [15:0] rd_count
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

  logic [SYNC_STAGES-1:0] clk_sq, rw_sq, rst_sq;
  logic [15:0]            addr_sq [SYNC_STAGES];
  logic [7:0]             din_sq  [SYNC_STAGES];

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sq <= '0;
      rw_sq  <= '1;
      rst_sq <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        addr_sq[i] <= '0;
        din_sq[i]  <= '0;
      end
    end else begin
      clk_sq     <= {clk_sq[SYNC_STAGES-2:0], a8_clk};
      rw_sq      <= {rw_sq[SYNC_STAGES-2:0], a8_rw_n};
      rst_sq     <= {rst_sq[SYNC_STAGES-2:0], a8_rst_n};
      addr_sq[0] <= a8_addr;
      din_sq[0]  <= a8_data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        addr_sq[i] <= addr_sq[i-1];
        din_sq[i]  <= din_sq[i-1];
      end
    end
  end

  logic        phi2_s, rw_s, a8rst_s;
  logic [15:0] addr_s;
  logic [7:0]  din_s;

  assign phi2_s  = clk_sq[SYNC_STAGES-1];
  assign rw_s    = rw_sq[SYNC_STAGES-1];
  assign a8rst_s = rst_sq[SYNC_STAGES-1];
  assign addr_s  = addr_sq[SYNC_STAGES-1];
  assign din_s   = din_sq[SYNC_STAGES-1];

  logic phi2_prev_q;
  logic rise, fall, hit;

  assign rise = phi2_s & ~phi2_prev_q;
  assign fall = ~phi2_s & phi2_prev_q;
  assign hit  = (addr_s[15:4] == WINDOW_BASE[15:4]);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          extsel_n_q, extsel_n_d;
  logic          wr_evt_q, wr_evt_d;
  logic [3:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [15:0]   rd_count_q, rd_count_d;
  logic          a8_we;
  logic [7:0]    regfile_q [16];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    extsel_n_d = extsel_n_q;
    wr_evt_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_count_d = rd_count_q;
    a8_we      = 1'b0;
    if (!a8rst_s) begin
      state_d    = IDLE;
      oe_d       = 1'b0;
      extsel_n_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          oe_d       = 1'b0;
          extsel_n_d = 1'b1;
          if (rise && hit) begin
            idx_d = addr_s[3:0];
            if (rw_s) begin
              state_d    = DRIVE;
              dout_d     = regfile_q[addr_s[3:0]];
              rd_count_d = rd_count_q + 16'd1;
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        DRIVE: begin
          extsel_n_d = 1'b0;
          oe_d       = 1'b1;
          if (fall) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
        CAPTURE: begin
          extsel_n_d = 1'b0;
          if (fall) begin
            state_d   = HOLD;
            cnt_d     = HOLD_LOAD;
            a8_we     = 1'b1;
            wr_evt_d  = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = din_s;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d    = IDLE;
            oe_d       = 1'b0;
            extsel_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phi2_prev_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      extsel_n_q  <= 1'b1;
      wr_evt_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      phi2_prev_q <= phi2_s;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      extsel_n_q  <= extsel_n_d;
      wr_evt_q    <= wr_evt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_count_q  <= rd_count_d;
    end
  end

  // A host write colliding with an A8 write to the same entry is dropped.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) regfile_q[i] <= '0;
    end else begin
      if (a8_we) regfile_q[idx_q] <= wr_data_d;
      if (reg_we && !(a8_we && (reg_addr == idx_q))) regfile_q[reg_addr] <= reg_wdata;
    end
  end

  assign a8_data_out = dout_q;
  assign a8_data_oe  = oe_q;
  assign a8_extsel_n = extsel_n_q;
  assign wr_evt      = wr_evt_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_count    = rd_count_q;

`ifdef A8_MPD_RESPONDER_EN
  logic mpd_n_q;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) mpd_n_q <= 1'b1;
    else        mpd_n_q <= ~(a8rst_s && mpd_req && (addr_s[15:11] == 5'b11011));
  end

  assign a8_mpd_n = mpd_n_q;
`else
  logic unused_mpd_req;

  assign unused_mpd_req = mpd_req;
  assign a8_mpd_n       = 1'b1;
`endif

endmodule

// File: tb/tb_a8_bus_responder.sv
// Scoreboard bench for a8_bus_responder: stimulus pushes expected reads/writes, a monitor pops on oe rise / wr_evt.
`timescale 1ns/1ps
module tb_a8_bus_responder;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int HI   = 8;

  logic        clk200 = 1'b0;
  logic        rst_n = 1'b0;
  logic        a8_clk = 1'b0, a8_rw_n = 1'b1, a8_rst_n = 1'b1;
  logic [15:0] a8_addr = 16'h0000;
  logic [7:0]  a8_data_in = 8'h00;
  logic [7:0]  a8_data_out;
  logic        a8_data_oe, a8_extsel_n, a8_mpd_n;
  logic        reg_we = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [7:0]  reg_wdata = 8'h00;
  logic        wr_evt;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        mpd_req = 1'b0;
  logic [15:0] rd_count;

  a8_bus_responder #(
    .WINDOW_BASE(16'hD1F0),
    .HOLD_CYCLES(HOLD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk200(clk200), .rst_n(rst_n),
    .a8_clk(a8_clk), .a8_rw_n(a8_rw_n), .a8_rst_n(a8_rst_n),
    .a8_addr(a8_addr), .a8_data_in(a8_data_in),
    .a8_data_out(a8_data_out), .a8_data_oe(a8_data_oe),
    .a8_extsel_n(a8_extsel_n), .a8_mpd_n(a8_mpd_n),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .wr_evt(wr_evt), .wr_addr(wr_addr), .wr_data(wr_data),
    .mpd_req(mpd_req), .rd_count(rd_count)
  );

  always #5 clk200 = ~clk200;

  typedef struct packed {
    logic       is_wr;
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_rd = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every oe rise is a served read, every wr_evt an A8 write.
  logic oe_prev = 1'b0, wev_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk200) begin
    if (rst_n) begin
      if (a8_data_oe && !oe_prev) begin
        if (sb_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          chk("sb_kind_read", {31'd0, mon_e.is_wr}, 32'd0);
          chk("sb_read_data", {24'd0, a8_data_out}, {24'd0, mon_e.d});
        end
      end
      if (wr_evt) begin
        chk("wr_evt_width", {31'd0, wev_prev}, 32'd0);
        if (sb_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          mon_e = sb_q.pop_front();
          chk("sb_kind_write", {31'd0, mon_e.is_wr}, 32'd1);
          chk("sb_wr_addr", {28'd0, wr_addr}, {28'd0, mon_e.a});
          chk("sb_wr_data", {24'd0, wr_data}, {24'd0, mon_e.d});
        end
      end
    end
    oe_prev  = a8_data_oe;
    wev_prev = wr_evt;
  end

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk200); #1;
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk200); #1;
    reg_we = 1'b0;
  endtask

  task automatic a8_read(input logic [15:0] addr, input bit hit, input logic [7:0] exp_d,
                         input bit poke, input logic [7:0] poke_d, input bit abort);
    int oe_seen = 0, sel_seen = 0, bad_dout = 0;
    @(posedge clk200); #1;
    a8_addr = addr; a8_rw_n = 1'b1;
    @(posedge clk200); #1;
    a8_clk = 1'b1;
    if (hit) begin
      sb_q.push_back('{1'b0, addr[3:0], exp_d});
      exp_rd = exp_rd + 16'd1;
    end
    for (int k = 1; k <= HI; k++) begin
      @(posedge clk200); #1;
      if (poke && k == SYNC+2) begin reg_we = 1'b1; reg_addr = addr[3:0]; reg_wdata = poke_d; end
      if (poke && k == SYNC+3) reg_we = 1'b0;
      if (abort && k == SYNC+2) a8_rst_n = 1'b0;
      @(negedge clk200);
      if (k == SYNC+1) chk("pre_rise_oe", {31'd0, a8_data_oe}, 32'd0);
      if (k == SYNC+2) begin
        chk("rise_latency_oe", {31'd0, a8_data_oe}, {31'd0, hit});
        chk("rise_latency_sel", {31'd0, a8_extsel_n}, {31'd0, !hit});
      end
      if (abort && k == 2*SYNC+3) begin
        chk("abort_oe", {31'd0, a8_data_oe}, 32'd0);
        chk("abort_sel", {31'd0, a8_extsel_n}, 32'd1);
      end
      if (a8_data_oe) begin oe_seen++; if (a8_data_out !== exp_d) bad_dout++; end
      if (!a8_extsel_n) sel_seen++;
    end
    @(posedge clk200); #1;
    a8_clk = 1'b0;
    for (int k = 1; k <= SYNC+HOLD+3; k++) begin
      @(posedge clk200);
      @(negedge clk200);
      if (!abort && hit && k == SYNC+HOLD) chk("hold_still_on", {31'd0, a8_data_oe}, 32'd1);
      if (!abort && hit && k == SYNC+HOLD+1) begin
        chk("release_oe", {31'd0, a8_data_oe}, 32'd0);
        chk("release_sel", {31'd0, a8_extsel_n}, 32'd1);
      end
      if (a8_data_oe) begin oe_seen++; if (a8_data_out !== exp_d) bad_dout++; end
      if (!a8_extsel_n) sel_seen++;
    end
    if (abort) begin
      a8_rst_n = 1'b1;
      repeat (SYNC+3) @(posedge clk200);
      @(negedge clk200);
      chk("after_abort_idle_oe", {31'd0, a8_data_oe}, 32'd0);
    end
    if (hit) chk("dout_stable", bad_dout, 0);
    else begin
      chk("nohit_oe", oe_seen, 0);
      chk("nohit_sel", sel_seen, 0);
    end
    chk("rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
  endtask

  task automatic a8_write(input logic [15:0] addr, input logic [7:0] d,
                          input bit collide, input logic [7:0] host_d);
    int oe_seen = 0, sel_seen = 0;
    @(posedge clk200); #1;
    a8_addr = addr; a8_rw_n = 1'b0; a8_data_in = d;
    @(posedge clk200); #1;
    a8_clk = 1'b1;
    sb_q.push_back('{1'b1, addr[3:0], d});
    for (int k = 1; k <= HI; k++) begin
      @(negedge clk200);
      if (a8_data_oe) oe_seen++;
      if (!a8_extsel_n) sel_seen++;
    end
    @(posedge clk200); #1;
    a8_clk = 1'b0;
    for (int k = 1; k <= SYNC+HOLD+3; k++) begin
      @(posedge clk200); #1;
      if (collide && k == SYNC) begin reg_we = 1'b1; reg_addr = addr[3:0]; reg_wdata = host_d; end
      if (collide && k == SYNC+1) reg_we = 1'b0;
      @(negedge clk200);
      if (a8_data_oe) oe_seen++;
      if (!a8_extsel_n) sel_seen++;
    end
    a8_rw_n = 1'b1;
    chk("write_oe_quiet", oe_seen, 0);
    chk("write_sel_seen", {31'd0, (sel_seen > 0)}, 32'd1);
  endtask

  initial begin
    logic exp_mpd;
    #23;
    chk("rst_extsel_n", {31'd0, a8_extsel_n}, 32'd1);
    chk("rst_mpd_n", {31'd0, a8_mpd_n}, 32'd1);
    chk("rst_oe", {31'd0, a8_data_oe}, 32'd0);
    chk("rst_dout", {24'd0, a8_data_out}, 32'd0);
    chk("rst_wr_evt", {31'd0, wr_evt}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    @(posedge clk200); #1;
    rst_n = 1'b1;
    repeat (SYNC+3) @(posedge clk200);

    a8_read(16'hD1F0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    host_write(4'h3, 8'hA5);
    a8_read(16'hD1F3, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    a8_read(16'hD1F3, 1'b1, 8'hA5, 1'b1, 8'h77, 1'b0);
    a8_read(16'hD1F3, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);

    a8_write(16'hD1FA, 8'h5C, 1'b0, 8'h00);
    a8_read(16'hD1FA, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b0);

    a8_read(16'hD200, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    a8_read(16'hD1FA, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b1);
    a8_read(16'hD1FA, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b0);
    a8_read(16'hD1F3, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);

    a8_write(16'hD1F2, 8'hC3, 1'b1, 8'h33);
    a8_read(16'hD1F2, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);

    @(posedge clk200); #1;
    force dut.rd_count_q = 16'hFFFF;
    repeat (2) @(posedge clk200);
    #1;
    release dut.rd_count_q;
    @(negedge clk200);
    chk("rd_count_preset", {16'd0, rd_count}, 32'h0000FFFF);
    exp_rd = 16'hFFFF;
    a8_read(16'hD1F3, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    chk("rd_count_wrap", {16'd0, rd_count}, 32'd0);

`ifdef A8_MPD_RESPONDER_EN
    exp_mpd = 1'b0;
`else
    exp_mpd = 1'b1;
`endif
    @(posedge clk200); #1;
    mpd_req = 1'b1; a8_addr = 16'hD800;
    repeat (SYNC+3) @(posedge clk200);
    @(negedge clk200);
    chk("mpd_d800", {31'd0, a8_mpd_n}, {31'd0, exp_mpd});
    @(posedge clk200); #1;
    a8_addr = 16'hE000;
    repeat (SYNC+3) @(posedge clk200);
    @(negedge clk200);
    chk("mpd_e000", {31'd0, a8_mpd_n}, 32'd1);
    mpd_req = 1'b0;

    repeat (4) @(posedge clk200);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
